// File: rtl/cross_bar_pkg.sv
// -----------------------------------------------------------------------------
// cross_bar_pkg
// Shared widths, data types and the arbiter state encoding for the crossbar
// slave-side arbitration logic.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package cross_bar_pkg;

    localparam int N_MASTERS = 4;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cross_bar_rr_picker.sv
// -----------------------------------------------------------------------------
// cross_bar_rr_picker
// Purely combinational round-robin selector. Searches the request vector
// upward from rr_ptr, wrapping at N_MASTERS-1, and returns the first hit.
//
// Ports
//   req     in   [N_MASTERS-1:0]  request vector
//   rr_ptr  in   [GNT_W-1:0]      search start index (always < N_MASTERS)
//   winner  out  [GNT_W-1:0]      index of the selected requester
//   valid   out  1                at least one request present
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module cross_bar_rr_picker #(
    parameter int N_MASTERS = cross_bar_pkg::N_MASTERS,
    parameter int GNT_W     = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [GNT_W-1:0]     rr_ptr,
    output logic [GNT_W-1:0]     winner,
    output logic                 valid
);
    import cross_bar_pkg::*;

    // cand[k] is the index examined at search offset k from rr_ptr.
    logic [GNT_W-1:0] cand [N_MASTERS];

    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_cand
        logic [GNT_W:0] sum;
        // rr_ptr < N_MASTERS, so one conditional subtraction is a full modulo.
        assign sum       = {1'b0, rr_ptr} + (GNT_W+1)'(gi);
        assign cand[gi]  = (sum >= (GNT_W+1)'(N_MASTERS))
                         ? GNT_W'(sum - (GNT_W+1)'(N_MASTERS))
                         : sum[GNT_W-1:0];
    end

    // Scan from the largest offset down so the smallest offset wins last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                winner = cand[k];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cross_bar_slave_arbiter.sv
// -----------------------------------------------------------------------------
// cross_bar_slave_arbiter
// Round-robin arbiter granting one of N_MASTERS request ports access to a
// single downstream slave port. A two-state FSM (IDLE/BUSY) holds the grant
// for the whole transaction; one IDLE cycle always separates transactions.
//
// Ports
//   clk, aresetn                    clock, asynchronous active-low reset
//   master_req/addr/cmd/wdata  in   per-master request (cmd: 0 read, 1 write)
//   master_ack/rdata           out  per-master completion pulse and read data
//   slave_req/addr/cmd/wdata   out  request muxed from the granted master
//   slave_ack/rdata            in   slave completion pulse and read data
//   gnt_id, gnt_valid          out  granted index, high while BUSY
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module cross_bar_slave_arbiter #(
    parameter int N_MASTERS = cross_bar_pkg::N_MASTERS,
    parameter int GNT_W     = $clog2(N_MASTERS)
) (
    input  logic                                    clk,
    input  logic                                    aresetn,
    input  logic [N_MASTERS-1:0]                    master_req,
    input  cross_bar_pkg::addr_t [N_MASTERS-1:0]    master_addr,
    input  logic [N_MASTERS-1:0]                    master_cmd,
    input  cross_bar_pkg::data_t [N_MASTERS-1:0]    master_wdata,
    output logic [N_MASTERS-1:0]                    master_ack,
    output cross_bar_pkg::data_t [N_MASTERS-1:0]    master_rdata,
    output logic                                    slave_req,
    output cross_bar_pkg::addr_t                    slave_addr,
    output logic                                    slave_cmd,
    output cross_bar_pkg::data_t                    slave_wdata,
    input  logic                                    slave_ack,
    input  cross_bar_pkg::data_t                    slave_rdata,
    output logic [GNT_W-1:0]                        gnt_id,
    output logic                                    gnt_valid
);
    import cross_bar_pkg::*;

    arb_state_t       state_reg, state_next;
    logic [GNT_W-1:0] gnt_id_reg, gnt_id_next;
    logic [GNT_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [GNT_W-1:0] pick_id;
    logic             pick_valid;
    logic             busy;

    cross_bar_rr_picker #(
        .N_MASTERS (N_MASTERS),
        .GNT_W     (GNT_W)
    ) u_picker (
        .req    (master_req),
        .rr_ptr (rr_ptr_reg),
        .winner (pick_id),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg  <= ST_IDLE;
            gnt_id_reg <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            gnt_id_reg <= gnt_id_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        gnt_id_next = gnt_id_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next  = ST_BUSY;
                    gnt_id_next = pick_id;
                end
            end
            ST_BUSY: begin
                // A dropped master_req does not end the transaction; only
                // the slave's ack does.
                if (slave_ack) begin
                    state_next  = ST_IDLE;
                    rr_ptr_next = (gnt_id_reg == GNT_W'(N_MASTERS - 1))
                                ? '0 : gnt_id_reg + GNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy      = (state_reg == ST_BUSY);
    assign gnt_valid = busy;
    assign gnt_id    = gnt_id_reg;

    always_comb begin
        slave_req   = 1'b0;
        slave_addr  = '0;
        slave_cmd   = 1'b0;
        slave_wdata = '0;
        if (busy) begin
            slave_req   = master_req[gnt_id_reg];
            slave_addr  = master_addr[gnt_id_reg];
            slave_cmd   = master_cmd[gnt_id_reg];
            slave_wdata = master_wdata[gnt_id_reg];
        end
    end

    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master_ret
        logic sel;
        assign sel              = busy && (gnt_id_reg == GNT_W'(gi));
        assign master_ack[gi]   = sel && slave_ack;
        assign master_rdata[gi] = sel ? slave_rdata : '0;
    end

endmodule

// File: tb/tb_cross_bar_slave_arbiter.sv
`timescale 1ns/1ps
module tb_cross_bar_slave_arbiter;
    import cross_bar_pkg::*;

    localparam int NM = 4;
    localparam int GW = 2;

    logic                  clk = 1'b0;
    logic                  aresetn;
    logic [NM-1:0]         master_req;
    addr_t [NM-1:0]        master_addr;
    logic [NM-1:0]         master_cmd;
    data_t [NM-1:0]        master_wdata;
    logic [NM-1:0]         master_ack;
    data_t [NM-1:0]        master_rdata;
    logic                  slave_req;
    addr_t                 slave_addr;
    logic                  slave_cmd;
    data_t                 slave_wdata;
    logic                  slave_ack;
    data_t                 slave_rdata;
    logic [GW-1:0]         gnt_id;
    logic                  gnt_valid;

    cross_bar_slave_arbiter #(.N_MASTERS(NM), .GNT_W(GW)) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .master_req   (master_req),
        .master_addr  (master_addr),
        .master_cmd   (master_cmd),
        .master_wdata (master_wdata),
        .master_ack   (master_ack),
        .master_rdata (master_rdata),
        .slave_req    (slave_req),
        .slave_addr   (slave_addr),
        .slave_cmd    (slave_cmd),
        .slave_wdata  (slave_wdata),
        .slave_ack    (slave_ack),
        .slave_rdata  (slave_rdata),
        .gnt_id       (gnt_id),
        .gnt_valid    (gnt_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    id;
        addr_t addr;
        logic  cmd;
        data_t wdata;
        int    gap;     // cycles from previous ack to grant, -1 = unchecked
    } grant_exp_t;

    typedef struct {
        int    id;
        data_t rdata;
    } ack_exp_t;

    grant_exp_t grant_q[$];
    ack_exp_t   ack_q[$];
    int checks = 0;
    int errors = 0;
    int slave_lat = 3;

    function automatic data_t slave_resp(addr_t a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- slave responder ----------------
    initial begin
        int wait_cnt;
        slave_ack   = 1'b0;
        slave_rdata = '0;
        wait_cnt    = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!aresetn || slave_ack) begin
                slave_ack   = 1'b0;
                slave_rdata = '0;
                wait_cnt    = 0;
            end else if (slave_req) begin
                wait_cnt++;
                if (wait_cnt >= slave_lat) begin
                    slave_ack   = 1'b1;
                    slave_rdata = slave_resp(slave_addr);
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int   cyc_cnt;
        int   last_ack_cyc;
        logic prev_gv;
        cyc_cnt      = 0;
        last_ack_cyc = -100;
        prev_gv      = 1'b0;
        forever begin
            @(negedge clk);
            cyc_cnt++;
            if (master_ack != '0) begin
                if (ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack actual=%b required=none", master_ack);
                end else begin
                    ack_exp_t e;
                    e = ack_q.pop_front();
                    check("ack_onehot", master_ack, 64'd1 << e.id);
                    for (int k = 0; k < NM; k++)
                        check("ack_rdata", master_rdata[k], (k == e.id) ? e.rdata : 32'h0);
                    $display("ack    master=%0d rdata=%h", e.id, master_rdata[e.id]);
                end
                last_ack_cyc = cyc_cnt;
            end
            if (gnt_valid && !prev_gv) begin
                if (grant_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant actual=%0d required=none", gnt_id);
                end else begin
                    grant_exp_t g;
                    g = grant_q.pop_front();
                    check("gnt_id", gnt_id, g.id);
                    check("slave_req", slave_req, 1);
                    check("slave_addr", slave_addr, g.addr);
                    check("slave_cmd", slave_cmd, g.cmd);
                    check("slave_wdata", slave_wdata, g.wdata);
                    if (g.gap >= 0)
                        check("grant_gap", cyc_cnt - last_ack_cyc, g.gap);
                    $display("grant  master=%0d addr=%h cmd=%0d", gnt_id, slave_addr, slave_cmd);
                end
            end
            prev_gv = gnt_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge: remember acks, move to just after the next edge and
    // drop the request of every master that completed.
    task automatic finish_cycle();
        logic [NM-1:0] acked;
        acked = master_ack;
        @(posedge clk);
        #1;
        master_req = master_req & ~acked;
    endtask

    task automatic cyc();
        @(negedge clk);
        finish_cycle();
    endtask

    // Returns at the negedge of master m's ack cycle.
    task automatic wait_ack(int m);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (master_ack[m]) return;
            finish_cycle();
        end
        checks++;
        errors++;
        $display("FAIL ack_timeout master=%0d actual=none required=ack", m);
        @(negedge clk);
    endtask

    task automatic issue(int m, addr_t a, logic c, data_t w, int gap, bit expect_ack = 1'b1);
        grant_exp_t g;
        ack_exp_t   e;
        master_req[m]   = 1'b1;
        master_addr[m]  = a;
        master_cmd[m]   = c;
        master_wdata[m] = w;
        g.id = m; g.addr = a; g.cmd = c; g.wdata = w; g.gap = gap;
        grant_q.push_back(g);
        if (expect_ack) begin
            e.id = m;
            e.rdata = slave_resp(a);
            ack_q.push_back(e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        aresetn      = 1'b0;
        master_req   = '0;
        master_addr  = '0;
        master_cmd   = '0;
        master_wdata = '0;
        repeat (2) cyc();
        @(negedge clk);
        check("rst_gnt_valid", gnt_valid, 0);
        check("rst_slave_req", slave_req, 0);
        check("rst_master_ack", master_ack, 0);
        check("rst_gnt_id", gnt_id, 0);
        finish_cycle();
        aresetn = 1'b1;

        // Single read, master 2, slave acks after 3 cycles.
        slave_lat = 3;
        issue(2, 32'h10, 1'b0, 32'h0, -1);
        @(negedge clk);
        check("latency_idle_req", slave_req, 0);
        finish_cycle();
        @(negedge clk);
        check("latency_busy_req", slave_req, 1);
        finish_cycle();
        wait_ack(2);
        finish_cycle();

        // Wrap-around: pointer is now 3, only master 0 requests.
        issue(0, 32'h20, 1'b1, 32'h1111_0000, 2);
        wait_ack(0);
        finish_cycle();
        // Pointer should be 1: with masters 0 and 1 both waiting, 1 goes first.
        issue(1, 32'h21, 1'b0, 32'h0, 2);
        issue(0, 32'h22, 1'b1, 32'h2222_0000, 2);
        wait_ack(1);
        finish_cycle();
        wait_ack(0);
        finish_cycle();

        // Contention from reset: masters 0, 1, 3 write; 0 re-requests.
        aresetn = 1'b0;
        repeat (2) cyc();
        aresetn = 1'b1;
        issue(0, 32'h100, 1'b1, 32'hA0, -1);
        issue(1, 32'h101, 1'b1, 32'hA1, 2);
        issue(3, 32'h103, 1'b1, 32'hA3, 2);
        wait_ack(0);
        finish_cycle();
        issue(0, 32'h200, 1'b1, 32'hB0, 2);
        wait_ack(1);
        finish_cycle();
        wait_ack(3);
        finish_cycle();
        wait_ack(0);
        finish_cycle();

        // Grant stability: master 0 shows up while master 1 is being served.
        slave_lat = 4;
        issue(1, 32'h301, 1'b0, 32'h0, -1);
        cyc();
        cyc();
        issue(0, 32'h300, 1'b1, 32'hC0, 2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("gnt_stable", gnt_id, 1);
            if (master_ack[1]) break;
            finish_cycle();
        end
        finish_cycle();
        wait_ack(0);
        finish_cycle();

        // Master 1 requests in the same cycle master 3 is acked.
        slave_lat = 2;
        issue(3, 32'h403, 1'b1, 32'hD3, -1);
        wait_ack(3);
        issue(1, 32'h401, 1'b0, 32'h0, 2);
        finish_cycle();
        wait_ack(1);
        finish_cycle();

        // Granted master drops its request mid-transaction.
        slave_lat = 5;
        issue(2, 32'h502, 1'b1, 32'hE2, -1);
        cyc();
        cyc();
        master_req[2] = 1'b0;
        @(negedge clk);
        check("drop_slave_req", slave_req, 0);
        check("drop_gnt_valid", gnt_valid, 1);
        check("drop_gnt_id", gnt_id, 2);
        finish_cycle();
        @(negedge clk);
        check("drop_hold_busy", gnt_valid, 1);
        finish_cycle();
        master_req[2] = 1'b1;
        wait_ack(2);
        finish_cycle();

        // Reset while busy with master 2: abort, no ack, restart from index 0.
        slave_lat = 10;
        issue(2, 32'h602, 1'b0, 32'h0, -1, 1'b0);
        cyc();
        cyc();
        aresetn = 1'b0;
        #1;
        check("arst_gnt_valid", gnt_valid, 0);
        check("arst_slave_req", slave_req, 0);
        check("arst_gnt_id", gnt_id, 0);
        check("arst_master_ack", master_ack, 0);
        master_req = '0;
        cyc();
        cyc();
        aresetn = 1'b1;
        issue(0, 32'h700, 1'b0, 32'h0, -1);
        issue(3, 32'h703, 1'b1, 32'hF3, 2);
        wait_ack(0);
        finish_cycle();
        wait_ack(3);
        finish_cycle();

        repeat (3) cyc();
        check("grant_q_drained", grant_q.size(), 0);
        check("ack_q_drained", ack_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cross_bar_slave_arbiter.md
CROSS_BAR_SLAVE_ARBITER -- requirements
Module: cross_bar_slave_arbiter

Interface
REQ-001 Parameter N_MASTERS, default cross_bar_pkg::N_MASTERS (4), is the number of master request ports competing for one slave port.
REQ-002 Parameter GNT_W, default $clog2(N_MASTERS), is the width of the grant index.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 aresetn  input  1  reset, asynchronous assert, active-low.
REQ-005 master_req  input  N_MASTERS  per-master request, held high until that master's ack.
REQ-006 master_addr  input  N_MASTERS x ADDR_W (addr_t)  per-master address.
REQ-007 master_cmd  input  N_MASTERS  per-master command: 0 = read, 1 = write.
REQ-008 master_wdata  input  N_MASTERS x DATA_W (data_t)  per-master write data.
REQ-009 master_ack  output  N_MASTERS  per-master one-cycle completion pulse.
REQ-010 master_rdata  output  N_MASTERS x DATA_W (data_t)  per-master read data, valid in the ack cycle.
REQ-011 slave_req, slave_addr, slave_cmd, slave_wdata  output  1/ADDR_W/1/DATA_W  request to the downstream slave port.
REQ-012 slave_ack  input  1  slave completion pulse; slave_rdata  input  DATA_W  read data, valid with slave_ack.
REQ-013 gnt_id  output  GNT_W  index of the currently granted master; gnt_valid  output  1  high in BUSY.

Function
REQ-014 The FSM SHALL have two states: IDLE and BUSY.
REQ-015 In IDLE, when any master_req bit is high, the block SHALL latch the winner into gnt_id and enter BUSY on the next edge.
REQ-016 The winner SHALL be the first requesting index found when searching upward from rr_ptr, wrapping from N_MASTERS-1 to 0.
REQ-017 In IDLE, slave_req SHALL be 0 and every master_ack bit SHALL be 0.
REQ-018 In BUSY, slave_req/addr/cmd/wdata SHALL combinationally equal the granted master's req/addr/cmd/wdata.
REQ-019 In BUSY, master_ack[gnt_id] SHALL equal slave_ack, and master_rdata[gnt_id] SHALL equal slave_rdata, both combinationally.
REQ-020 Every non-granted master_ack bit SHALL be 0, and its master_rdata SHALL be 0.
REQ-021 On slave_ack in BUSY, the FSM SHALL return to IDLE and rr_ptr SHALL become gnt_id+1 modulo N_MASTERS.
REQ-022 A request reaches the slave one cycle after master_req rises, if the slave port is idle.
REQ-023 Back-to-back grants SHALL have exactly one IDLE bubble cycle between slave_ack and the next slave_req.
REQ-024 The grant SHALL NOT change while in BUSY, whatever other masters request.
REQ-025 A master's request arriving in the same cycle as another master's slave_ack SHALL be arbitrated in the following IDLE cycle.
REQ-026 If the granted master deasserts master_req while BUSY, slave_req SHALL drop.
REQ-027 That deassertion is a protocol violation; the FSM SHALL stay in BUSY until slave_ack.
REQ-028 Read and write transactions SHALL be handled identically by the arbiter.

Reset
REQ-029 While aresetn is low: state = IDLE, rr_ptr = 0, gnt_id = 0, gnt_valid = 0, slave_req = 0, all master_ack = 0.
REQ-030 Reset asserted mid-transaction SHALL abort it, with no ack delivered.
REQ-031 After reset release, the first arbitration SHALL start from index 0.

Structure
REQ-032 cross_bar_pkg SHALL hold ADDR_W, DATA_W, addr_t, data_t and N_MASTERS; no local redefinitions are allowed.
REQ-033 Sub-module cross_bar_rr_picker SHALL be purely combinational, taking request vector and rr_ptr and returning a winner index and a valid flag.
REQ-034 The FSM, rr_ptr and gnt_id registers and the slave/master muxing SHALL live in cross_bar_slave_arbiter.

Verification
REQ-035 Single read: master 2 requests with addr 0x10 and cmd 0; the slave acks with 0xDEAD_BEEF after 3 cycles.
-> slave_req is high from cycle 1; master_ack[2] pulses with master_rdata[2] = 0xDEAD_BEEF; all other acks stay 0.
REQ-036 Contention: masters 0, 1 and 3 hold writes from reset.
-> The grant order is 0, 1, 3, 0, with one bubble cycle between each transaction.
REQ-037 Grant stability: master 1 is granted and master 0 raises its request mid-transaction.
-> gnt_id stays 1 until slave_ack; master 0 is granted next.
REQ-038 Wrap-around: rr_ptr = 3 and only master 0 requests.
-> master 0 is granted, and rr_ptr becomes 1 after its ack.
REQ-039 Reset mid-operation: aresetn drops while BUSY with master 2.
-> Outputs take the REQ-029 values within the same cycle, with no master_ack[2]; after release, master 0 wins first.
REQ-040 Simultaneous ack and new request: master 3 acks in the same cycle master 1 raises its request.
-> One IDLE cycle follows, then master 1 is granted.
